// File: rtl/dual_pipe_sequencer_if.sv
// Producer handshake and lockstep pipeline issue/retire bus for dual_pipe_sequencer.
interface dual_pipe_sequencer_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic              src_ready;
    logic [DATA_W-1:0] pipeline1_inputs;
    logic [DATA_W-1:0] pipeline2_inputs;
    logic              issue_valid;
    logic [1:0]        in_valid;

    modport master (
        output src_valid, src_data, in_valid,
        input  src_ready, pipeline1_inputs, pipeline2_inputs, issue_valid
    );

    modport slave (
        input  src_valid, src_data, in_valid,
        output src_ready, pipeline1_inputs, pipeline2_inputs, issue_valid
    );
endinterface

// File: rtl/dual_pipe_sequencer.sv
// Issue controller for two lockstep pipelines: credit tracking, drain and flush sequencing.
module dual_pipe_sequencer #(
    parameter int unsigned          DATA_W       = 32,
    parameter int unsigned          PIPE_DEPTH   = 4,
    parameter int unsigned          FLUSH_CYCLES = 4,
    parameter logic [DATA_W-1:0]    P2_MASK      = '0,
    localparam int unsigned         CNT_W        = $clog2(PIPE_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable_i,
    input  logic                 flush_req_i,
    dual_pipe_sequencer_if.slave bus,
    output logic                 flush_1_o,
    output logic                 flush_2_o,
    output logic [CNT_W-1:0]     inflight_o,
    output logic                 busy_o,
    output logic                 err_diverge_o,
    output logic                 err_underflow_o
);
    localparam int unsigned FC_W = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        DRAIN   = 3'd2,
        FLUSH   = 3'd3,
        RECOVER = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic [DATA_W-1:0] p1_q, p2_q;
    logic              issue_valid_q, flush_q, busy_q, err_div_q, err_und_q;

    logic in_ok, xfer, dec1, dec2, diverge, under1, under2, flush_go, ready_c;

    // Handshake, credit arithmetic and next-state selection
    always_comb begin
        in_ok    = (state_q == ISSUE) || (state_q == DRAIN);
        ready_c  = (state_q == ISSUE) && enable_i && !flush_req_i &&
                   (cnt1_q < CNT_W'(PIPE_DEPTH)) && (cnt2_q < CNT_W'(PIPE_DEPTH));
        xfer     = bus.src_valid && ready_c;
        dec1     = in_ok && bus.in_valid[0];
        dec2     = in_ok && bus.in_valid[1];
        diverge  = in_ok && (bus.in_valid[0] ^ bus.in_valid[1]);
        under1   = dec1 && (cnt1_q == '0) && !xfer;
        under2   = dec2 && (cnt2_q == '0) && !xfer;
        flush_go = in_ok && (flush_req_i || diverge || under1 || under2);

        cnt1_d  = cnt1_q;
        cnt2_d  = cnt2_q;
        fcnt_d  = fcnt_q;
        state_d = state_q;

        if (xfer && !dec1)                         cnt1_d = cnt1_q + CNT_W'(1);
        else if (!xfer && dec1 && cnt1_q != '0)    cnt1_d = cnt1_q - CNT_W'(1);
        if (xfer && !dec2)                         cnt2_d = cnt2_q + CNT_W'(1);
        else if (!xfer && dec2 && cnt2_q != '0)    cnt2_d = cnt2_q - CNT_W'(1);

        case (state_q)
            IDLE:    if (enable_i) state_d = ISSUE;
            ISSUE:   if (!enable_i) state_d = DRAIN;
            DRAIN:   if (cnt1_q == '0 && cnt2_q == '0) state_d = IDLE;
            FLUSH: begin
                if (fcnt_q == '0) state_d = RECOVER;
                else              fcnt_d  = fcnt_q - FC_W'(1);
            end
            RECOVER: state_d = enable_i ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase

        // Flush entry overrides drain/enable moves and drops same-cycle retires
        if (flush_go) begin
            state_d = FLUSH;
            fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
            cnt1_d  = '0;
            cnt2_d  = '0;
        end

        bus.src_ready = ready_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt1_q        <= '0;
            cnt2_q        <= '0;
            fcnt_q        <= '0;
            p1_q          <= '0;
            p2_q          <= '0;
            issue_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            busy_q        <= 1'b0;
            err_div_q     <= 1'b0;
            err_und_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt1_q        <= cnt1_d;
            cnt2_q        <= cnt2_d;
            fcnt_q        <= fcnt_d;
            issue_valid_q <= xfer && !flush_go;
            flush_q       <= (state_d == FLUSH);
            busy_q        <= (state_d != IDLE);
            err_div_q     <= err_div_q | diverge;
            err_und_q     <= err_und_q | under1 | under2;
            if (xfer) begin
                p1_q <= bus.src_data;
                p2_q <= bus.src_data ^ P2_MASK;
            end
        end
    end

    assign bus.issue_valid      = issue_valid_q;
    assign bus.pipeline1_inputs = p1_q;
    assign bus.pipeline2_inputs = p2_q;
    assign flush_1_o            = flush_q;
    assign flush_2_o            = flush_q;
    assign inflight_o           = cnt1_q;
    assign busy_o               = busy_q;
    assign err_diverge_o        = err_div_q;
    assign err_underflow_o      = err_und_q;
endmodule

// File: tb/tb_dual_pipe_sequencer.sv
// Directed bench for dual_pipe_sequencer: issue, credits, flush, divergence, underflow, drain, reset.
module tb_dual_pipe_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       flush_req;
    logic       flush_1, flush_2;
    logic [2:0] inflight;
    logic       busy, err_diverge, err_underflow;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    dual_pipe_sequencer_if #(.DATA_W(32)) bus ();

    dual_pipe_sequencer #(
        .DATA_W(32), .PIPE_DEPTH(4), .FLUSH_CYCLES(4), .P2_MASK(32'hFFFF_FFFF)
    ) dut (
        .clk(clk), .reset(reset), .enable_i(enable), .flush_req_i(flush_req),
        .bus(bus), .flush_1_o(flush_1), .flush_2_o(flush_2), .inflight_o(inflight),
        .busy_o(busy), .err_diverge_o(err_diverge), .err_underflow_o(err_underflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; flush_req = 1'b0;
        bus.src_valid = 1'b0; bus.src_data = '0; bus.in_valid = 2'b00;
        tick(); tick();
        checks++; if ({bus.issue_valid, flush_1, flush_2, busy, err_diverge, err_underflow} !== 6'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 000000",
                {bus.issue_valid, flush_1, flush_2, busy, err_diverge, err_underflow}); end
        checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL reset_inflight got %0d exp 0", inflight); end
        checks++; if (bus.pipeline1_inputs !== 32'h0) begin errors++; $display("FAIL reset_p1 got %h exp 0", bus.pipeline1_inputs); end
        reset = 1'b0;
        tick();
        #1;
        checks++; if (bus.src_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b exp 0", bus.src_ready); end
    endtask

    task automatic test_issue();
        enable = 1'b1;
        tick();
        bus.src_valid = 1'b1; bus.src_data = 32'h0001_0000;
        #1;
        checks++; if (bus.src_ready !== 1'b1) begin errors++; $display("FAIL issue_ready got %b exp 1", bus.src_ready); end
        tick();
        bus.src_valid = 1'b0; bus.src_data = 32'h5555_AAAA;
        checks++; if (bus.issue_valid !== 1'b1) begin errors++; $display("FAIL issue_valid got %b exp 1", bus.issue_valid); end
        checks++; if (bus.pipeline1_inputs !== 32'h0001_0000) begin errors++; $display("FAIL issue_p1 got %h exp 00010000", bus.pipeline1_inputs); end
        checks++; if (bus.pipeline2_inputs !== 32'hFFFE_FFFF) begin errors++; $display("FAIL issue_p2 got %h exp fffeffff", bus.pipeline2_inputs); end
        checks++; if (inflight !== 3'd1) begin errors++; $display("FAIL issue_inflight got %0d exp 1", inflight); end
        tick();
        checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL issue_pulse got %b exp 0", bus.issue_valid); end
        checks++; if (bus.pipeline1_inputs !== 32'h0001_0000) begin errors++; $display("FAIL issue_hold got %h exp 00010000", bus.pipeline1_inputs); end
        bus.in_valid = 2'b11;
        tick();
        bus.in_valid = 2'b00;
        checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL retire_inflight got %0d exp 0", inflight); end
    endtask

    task automatic test_credit_limit();
        int issues = 0;
        bus.src_valid = 1'b1; bus.src_data = 32'hCAFE_0001;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.issue_valid === 1'b1) issues++;
        end
        #1;
        checks++; if (issues != 4) begin errors++; $display("FAIL credit_issues got %0d exp 4", issues); end
        checks++; if (inflight !== 3'd4) begin errors++; $display("FAIL credit_inflight got %0d exp 4", inflight); end
        checks++; if (bus.src_ready !== 1'b0) begin errors++; $display("FAIL credit_ready got %b exp 0", bus.src_ready); end
        bus.in_valid = 2'b11; bus.src_data = 32'h1234_5678;
        tick();
        bus.in_valid = 2'b00;
        issues = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.issue_valid === 1'b1) issues++;
        end
        bus.src_valid = 1'b0;
        checks++; if (issues != 1) begin errors++; $display("FAIL credit_reissue got %0d exp 1", issues); end
        checks++; if (bus.pipeline2_inputs !== 32'hEDCB_A987) begin errors++; $display("FAIL credit_p2 got %h exp edcba987", bus.pipeline2_inputs); end
        checks++; if (inflight !== 3'd4) begin errors++; $display("FAIL credit_refill got %0d exp 4", inflight); end
    endtask

    task automatic test_flush();
        int fl = 0;
        bus.in_valid = 2'b11;
        tick(); tick();
        bus.in_valid = 2'b00;
        checks++; if (inflight !== 3'd2) begin errors++; $display("FAIL flush_pre got %0d exp 2", inflight); end
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        bus.in_valid = 2'b01;
        checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL flush_zero got %0d exp 0", inflight); end
        if (flush_1 === 1'b1 && flush_2 === 1'b1) fl++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (flush_1 === 1'b1 && flush_2 === 1'b1 && bus.issue_valid === 1'b0) fl++;
        end
        bus.in_valid = 2'b00;
        checks++; if (fl != 4) begin errors++; $display("FAIL flush_len got %0d exp 4", fl); end
        tick();
        checks++; if ({flush_1, flush_2, busy} !== 3'b001) begin errors++; $display("FAIL flush_recover got %b exp 001", {flush_1, flush_2, busy}); end
        checks++; if (err_diverge !== 1'b0) begin errors++; $display("FAIL flush_ignore got %b exp 0", err_diverge); end
        tick();
        #1;
        checks++; if (bus.src_ready !== 1'b1) begin errors++; $display("FAIL flush_reissue got %b exp 1", bus.src_ready); end
    endtask

    task automatic test_diverge();
        bus.src_valid = 1'b1; bus.src_data = 32'h0000_00A5;
        tick();
        bus.src_valid = 1'b0;
        checks++; if (inflight !== 3'd1) begin errors++; $display("FAIL div_pre got %0d exp 1", inflight); end
        bus.in_valid = 2'b01;
        tick();
        bus.in_valid = 2'b00;
        checks++; if ({err_diverge, flush_1, inflight} !== {2'b11, 3'd0}) begin
            errors++; $display("FAIL div_entry got %b exp 11000", {err_diverge, flush_1, inflight}); end
        for (int i = 0; i < 4; i++) tick();
        checks++; if ({err_diverge, flush_1, busy} !== 3'b101) begin errors++; $display("FAIL div_sticky got %b exp 101", {err_diverge, flush_1, busy}); end
        tick();
    endtask

    task automatic test_underflow();
        bus.in_valid = 2'b11;
        tick();
        bus.in_valid = 2'b00;
        checks++; if ({err_underflow, flush_1, inflight} !== {2'b11, 3'd0}) begin
            errors++; $display("FAIL under_entry got %b exp 11000", {err_underflow, flush_1, inflight}); end
        for (int i = 0; i < 5; i++) tick();
        checks++; if ({err_underflow, err_diverge, flush_2} !== 3'b110) begin
            errors++; $display("FAIL under_sticky got %b exp 110", {err_underflow, err_diverge, flush_2}); end
    endtask

    task automatic test_drain();
        bus.src_valid = 1'b1; bus.src_data = 32'h0000_0003;
        tick(); tick(); tick();
        bus.src_valid = 1'b0;
        checks++; if (inflight !== 3'd3) begin errors++; $display("FAIL drain_pre got %0d exp 3", inflight); end
        enable = 1'b0;
        tick();
        #1;
        checks++; if ({busy, bus.src_ready} !== 2'b10) begin errors++; $display("FAIL drain_enter got %b exp 10", {busy, bus.src_ready}); end
        bus.in_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({busy, inflight} !== {1'b1, 3'(2 - i)}) begin
                errors++; $display("FAIL drain_step%0d got %b exp %b", i, {busy, inflight}, {1'b1, 3'(2 - i)}); end
        end
        bus.in_valid = 2'b00;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_idle got %b exp 0", busy); end
    endtask

    task automatic test_reset_in_flush();
        enable = 1'b1;
        tick();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        tick();
        checks++; if (flush_1 !== 1'b1) begin errors++; $display("FAIL rst_flush_pre got %b exp 1", flush_1); end
        reset = 1'b1;
        tick();
        checks++; if ({flush_1, flush_2, busy, err_diverge, err_underflow, inflight} !== 8'b0) begin
            errors++; $display("FAIL rst_flush got %b exp 00000000",
                {flush_1, flush_2, busy, err_diverge, err_underflow, inflight}); end
        reset = 1'b0; enable = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_issue();
        test_credit_limit();
        test_flush();
        test_diverge();
        test_underflow();
        test_drain();
        test_reset_in_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
